// File: rtl/wb_pkg.sv
// Shared write-back definitions: result-source encodings and entry record layout.
package wb_pkg;

  typedef enum logic [1:0] {
    WB_SEL_ALU  = 2'd0,
    WB_SEL_MEM  = 2'd1,
    WB_SEL_LINK = 2'd2,
    WB_SEL_RSVD = 2'd3
  } wb_sel_e;

  // Entry record is packed {data, rd, we}: we at bit 0, rd above it, data on top.
  function automatic int wb_ent_w(input int data_w, input int reg_aw);
    return data_w + reg_aw + 1;
  endfunction

endpackage

// File: rtl/wb_skid_fifo.sv
// Two-entry in-order buffer; head/tail registered, one-cycle write-to-read latency.
// Pushes are ignored when full and pops when empty, so the caller's qualifiers are the source of truth.
module wb_skid_fifo #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [1:0]   count,
  output logic [W-1:0] head,
  output logic [W-1:0] tail
);

  logic [W-1:0] slot0;
  logic [W-1:0] slot1;
  logic [1:0]   cnt;
  logic         do_push;
  logic         do_pop;

  assign do_push = push && (cnt != 2'd2);
  assign do_pop  = pop  && (cnt != 2'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= 2'd0;
      slot0 <= '0;
      slot1 <= '0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (cnt == 2'd0) slot0 <= wdata;
          else             slot1 <= wdata;
          cnt <= cnt + 2'd1;
        end
        // Vacated slots are cleared so an empty buffer always reads as zero.
        2'b01: begin
          slot0 <= slot1;
          slot1 <= '0;
          cnt   <= cnt - 2'd1;
        end
        2'b11: begin
          slot0 <= wdata;
        end
        default: ;
      endcase
    end
  end

  assign count = cnt;
  assign head  = slot0;
  assign tail  = slot1;

endmodule

// File: rtl/writeback_pipe.sv
// Write-back stage: selects result source, buffers 2 entries, drives register-file write and bypass.
// One-cycle latency; in_ready depends only on buffer occupancy, never on rf_ready.
module writeback_pipe
  import wb_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int REG_AW = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_sel,
  input  logic [DATA_W-1:0] in_alu,
  input  logic [DATA_W-1:0] in_mem,
  input  logic [DATA_W-1:0] in_link,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_we,
  output logic              rf_valid,
  input  logic              rf_ready,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_data,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_addr,
  output logic [DATA_W-1:0] fwd_data,
  output logic [CNT_W-1:0]  retired,
  output logic              err_sel
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [REG_AW-1:0] rd;
    logic              we;
  } ent_t;

  localparam int ENT_W = wb_ent_w(DATA_W, REG_AW);

  ent_t             new_ent;
  ent_t             head_ent;
  ent_t             tail_ent;
  logic [ENT_W-1:0] head_raw;
  logic [ENT_W-1:0] tail_raw;
  logic [1:0]       count;
  logic             accept;
  logic             pop;
  logic             head_fwd;
  logic             tail_fwd;
  logic [CNT_W-1:0] retired_q;
  logic             err_q;

  assign in_ready = (count != 2'd2);
  assign accept   = in_valid && in_ready;
  assign rf_valid = (count != 2'd0);
  assign pop      = rf_valid && rf_ready;

  // Reserved selector stores a harmless non-writing entry; rd kept for traceability.
  always_comb begin
    new_ent    = '0;
    new_ent.rd = in_rd;
    case (wb_sel_e'(in_sel))
      WB_SEL_ALU:  begin new_ent.data = in_alu;  new_ent.we = in_we; end
      WB_SEL_MEM:  begin new_ent.data = in_mem;  new_ent.we = in_we; end
      WB_SEL_LINK: begin new_ent.data = in_link; new_ent.we = in_we; end
      default:     begin new_ent.data = '0;      new_ent.we = 1'b0;  end
    endcase
  end

  wb_skid_fifo #(.W(ENT_W)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (accept),
    .pop   (pop),
    .wdata (new_ent),
    .count (count),
    .head  (head_raw),
    .tail  (tail_raw)
  );

  assign head_ent = ent_t'(head_raw);
  assign tail_ent = ent_t'(tail_raw);

  assign rf_addr = rf_valid ? head_ent.rd   : '0;
  assign rf_data = rf_valid ? head_ent.data : '0;
  assign rf_we   = rf_valid && head_ent.we && (head_ent.rd != '0);

  // The tail is the younger entry, so it wins the bypass when it qualifies.
  assign head_fwd = (count != 2'd0) && head_ent.we && (head_ent.rd != '0);
  assign tail_fwd = (count == 2'd2) && tail_ent.we && (tail_ent.rd != '0);

  always_comb begin
    fwd_valid = 1'b0;
    fwd_addr  = '0;
    fwd_data  = '0;
    if (tail_fwd) begin
      fwd_valid = 1'b1;
      fwd_addr  = tail_ent.rd;
      fwd_data  = tail_ent.data;
    end else if (head_fwd) begin
      fwd_valid = 1'b1;
      fwd_addr  = head_ent.rd;
      fwd_data  = head_ent.data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      retired_q <= '0;
      err_q     <= 1'b0;
    end else begin
      if (pop) retired_q <= retired_q + CNT_W'(1);
      if (accept && (in_sel == WB_SEL_RSVD)) err_q <= 1'b1;
    end
  end

  assign retired = retired_q;
  assign err_sel = err_q;

endmodule

// File: tb/tb_writeback_pipe.sv
// Directed bench for writeback_pipe with hand-computed expectations (CNT_W = 4 to reach wrap).
module tb_writeback_pipe;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_sel;
  logic [7:0] in_alu;
  logic [7:0] in_mem;
  logic [7:0] in_link;
  logic [2:0] in_rd;
  logic       in_we;
  logic       rf_valid;
  logic       rf_ready;
  logic       rf_we;
  logic [2:0] rf_addr;
  logic [7:0] rf_data;
  logic       fwd_valid;
  logic [2:0] fwd_addr;
  logic [7:0] fwd_data;
  logic [3:0] retired;
  logic       err_sel;

  int n_chk = 0;
  int n_err = 0;

  writeback_pipe #(.DATA_W(8), .REG_AW(3), .CNT_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_alu    (in_alu),
    .in_mem    (in_mem),
    .in_link   (in_link),
    .in_rd     (in_rd),
    .in_we     (in_we),
    .rf_valid  (rf_valid),
    .rf_ready  (rf_ready),
    .rf_we     (rf_we),
    .rf_addr   (rf_addr),
    .rf_data   (rf_data),
    .fwd_valid (fwd_valid),
    .fwd_addr  (fwd_addr),
    .fwd_data  (fwd_data),
    .retired   (retired),
    .err_sel   (err_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [1:0] sel, input logic [7:0] alu, input logic [7:0] mem,
                       input logic [7:0] link, input logic [2:0] rd, input logic we);
    in_valid = 1'b1;
    in_sel   = sel;
    in_alu   = alu;
    in_mem   = mem;
    in_link  = link;
    in_rd    = rd;
    in_we    = we;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_sel   = 2'd0;
    in_alu   = 8'h00;
    in_mem   = 8'h00;
    in_link  = 8'h00;
    in_rd    = 3'd0;
    in_we    = 1'b0;
    rf_ready = 1'b0;
    do_reset();

    chk("rst_in_ready", in_ready, 1);
    chk("rst_rf_valid", rf_valid, 0);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_rf_data", rf_data, 0);
    chk("rst_fwd_valid", fwd_valid, 0);
    chk("rst_retired", retired, 0);
    chk("rst_err_sel", err_sel, 0);

    // Single MEM-sourced write
    rf_ready = 1'b1;
    offer(2'd1, 8'h00, 8'hA5, 8'h00, 3'd3, 1'b1);
    step();
    in_valid = 1'b0;
    chk("s1_rf_valid", rf_valid, 1);
    chk("s1_rf_we", rf_we, 1);
    chk("s1_rf_addr", rf_addr, 3);
    chk("s1_rf_data", rf_data, 8'hA5);
    chk("s1_fwd_data", fwd_data, 8'hA5);
    chk("s1_retired_pre", retired, 0);
    step();
    chk("s1_retired", retired, 1);
    chk("s1_empty", rf_valid, 0);
    chk("s1_empty_data", rf_data, 0);

    // Backpressure: two accepts fill, third waits, order preserved
    rf_ready = 1'b0;
    offer(2'd0, 8'h11, 8'h00, 8'h00, 3'd1, 1'b1);
    step();
    chk("s2_ready_1", in_ready, 1);
    offer(2'd0, 8'h22, 8'h00, 8'h00, 3'd2, 1'b1);
    step();
    chk("s2_ready_full", in_ready, 0);
    chk("s2_head", rf_data, 8'h11);
    chk("s2_fwd_addr", fwd_addr, 2);
    offer(2'd0, 8'h33, 8'h00, 8'h00, 3'd3, 1'b1);
    step();
    chk("s2_still_full", in_ready, 0);
    chk("s2_head_stable", rf_data, 8'h11);
    chk("s2_addr_stable", rf_addr, 1);
    rf_ready = 1'b1;
    step();
    chk("s2_second", rf_data, 8'h22);
    chk("s2_ready_again", in_ready, 1);
    step();
    chk("s2_third", rf_data, 8'h33);
    chk("s2_third_addr", rf_addr, 3);
    in_valid = 1'b0;
    step();
    chk("s2_retired", retired, 4);
    chk("s2_drained", rf_valid, 0);

    // Register 0 write suppressed but still retired
    rf_ready = 1'b0;
    offer(2'd0, 8'h7F, 8'h00, 8'h00, 3'd0, 1'b1);
    step();
    in_valid = 1'b0;
    chk("s3_rf_valid", rf_valid, 1);
    chk("s3_rf_we", rf_we, 0);
    chk("s3_fwd_valid", fwd_valid, 0);
    rf_ready = 1'b1;
    step();
    chk("s3_retired", retired, 5);

    // Reserved selector
    rf_ready = 1'b0;
    offer(2'd3, 8'hAA, 8'hBB, 8'hCC, 3'd4, 1'b1);
    step();
    chk("s4_err", err_sel, 1);
    chk("s4_rf_we", rf_we, 0);
    chk("s4_rf_data", rf_data, 0);
    chk("s4_fwd_valid", fwd_valid, 0);
    rf_ready = 1'b1;
    offer(2'd2, 8'h00, 8'h00, 8'h5C, 3'd5, 1'b1);
    step();
    chk("s4_link_data", rf_data, 8'h5C);
    chk("s4_link_we", rf_we, 1);
    chk("s4_err_sticky", err_sel, 1);
    chk("s4_retired", retired, 6);
    in_valid = 1'b0;
    step();
    chk("s4_retired2", retired, 7);
    chk("s4_err_sticky2", err_sel, 1);

    // Forwarding picks youngest
    rf_ready = 1'b0;
    offer(2'd0, 8'h11, 8'h00, 8'h00, 3'd2, 1'b1);
    step();
    offer(2'd0, 8'h22, 8'h00, 8'h00, 3'd2, 1'b1);
    step();
    in_valid = 1'b0;
    chk("s5_fwd_two", fwd_data, 8'h22);
    chk("s5_fwd_addr", fwd_addr, 2);
    rf_ready = 1'b1;
    step();
    chk("s5_fwd_one", fwd_data, 8'h22);
    chk("s5_fwd_one_vld", fwd_valid, 1);
    step();
    chk("s5_fwd_none", fwd_valid, 0);
    chk("s5_fwd_none_data", fwd_data, 0);
    chk("s5_retired", retired, 9);

    // Counter wrap after 17 pops, then reset with a full buffer
    do_reset();
    chk("s6_retired_rst", retired, 0);
    chk("s6_err_rst", err_sel, 0);
    rf_ready = 1'b1;
    offer(2'd0, 8'h01, 8'h00, 8'h00, 3'd1, 1'b1);
    repeat (17) step();
    in_valid = 1'b0;
    step();
    chk("s6_wrap", retired, 1);
    rf_ready = 1'b0;
    offer(2'd0, 8'h44, 8'h00, 8'h00, 3'd6, 1'b1);
    step();
    step();
    chk("s6_full_vld", rf_valid, 1);
    chk("s6_full_ready", in_ready, 0);
    reset    = 1'b1;
    rf_ready = 1'b1;
    step();
    reset = 1'b0;
    chk("s6_rst_rf_valid", rf_valid, 0);
    chk("s6_rst_retired", retired, 0);
    chk("s6_rst_ready", in_ready, 1);
    chk("s6_rst_fwd", fwd_valid, 0);
    in_valid = 1'b0;
    step();
    chk("s6_post_retired", retired, 0);
    chk("s6_post_valid", rf_valid, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/writeback_pipe.md
WRITEBACK_PIPE -- requirements
Module: writeback_pipe

Interface
REQ-001 Parameter DATA_W, default 8, sets the result datapath width.
REQ-002 Parameter REG_AW, default 3, sets the destination register address width.
REQ-003 Parameter CNT_W, default 16, sets the retire counter width.
REQ-004 The module SHALL have these ports, one clock (clk) and one synchronous active-high reset (reset):
  clk        in   1        rising-edge clock
  reset      in   1        synchronous, active-high reset
  in_valid   in   1        upstream (data-memory stage) entry valid
  in_ready   out  1        block can accept an entry this cycle
  in_sel     in   2        result source: 00 ALU, 01 MEM, 10 LINK, 11 reserved
  in_alu     in   DATA_W   ALU result
  in_mem     in   DATA_W   data-memory load result
  in_link    in   DATA_W   link (return-address) value
  in_rd      in   REG_AW   destination register
  in_we      in   1        instruction writes a register
  rf_valid   out  1        write-back entry presented to the register file
  rf_ready   in   1        register file accepts the presented entry
  rf_we      out  1        effective register write enable
  rf_addr    out  REG_AW   register write address
  rf_data    out  DATA_W   register write data
  fwd_valid  out  1        bypass value available
  fwd_addr   out  REG_AW   bypass register address
  fwd_data   out  DATA_W   bypass data
  retired    out  CNT_W    count of entries written back
  err_sel    out  1        sticky: reserved in_sel was accepted

Function
REQ-005 Accept occurs when in_valid and in_ready are both 1; pop occurs when rf_valid and rf_ready are both 1.
REQ-006 Accepted entries SHALL be stored in a 2-entry in-order buffer holding {data, rd, we}; data = in_alu, in_mem or in_link per in_sel, selected at accept time.
REQ-007 in_ready SHALL equal (count < 2) and depend only on registered state, never on rf_ready.
REQ-008 Latency SHALL be one cycle: an entry accepted at edge N is presented on rf_* after edge N; there is no combinational in->rf path.
REQ-009 rf_valid = (count > 0); rf_addr/rf_data show the oldest entry; with count = 0 rf_addr, rf_data and rf_we SHALL be 0.
REQ-010 rf_we = rf_valid AND entry.we AND (entry.rd != 0); writes to register 0 are always suppressed, but the entry still pops.
REQ-011 Simultaneous accept and pop with count = 1 SHALL leave count = 1, with the new entry becoming head; with count = 2 no accept is possible.
REQ-012 rf_valid and head contents SHALL remain stable while rf_ready = 0.
REQ-013 An accept with in_sel = 11 SHALL store we = 0 and data = 0, and set err_sel, which stays 1 until reset.
REQ-014 fwd_valid/fwd_addr/fwd_data SHALL show the youngest buffered entry with we = 1 and rd != 0; if none exists, all three are 0.
REQ-015 retired SHALL increment by 1 on every pop (including suppressed writes) and wrap from 2^CNT_W-1 to 0.

Reset
REQ-016 While reset = 1 at a clock edge: count = 0, buffer contents = 0, retired = 0, err_sel = 0; therefore in_ready = 1 and rf_valid = rf_we = fwd_valid = 0.
REQ-017 Reset mid-operation SHALL discard buffered entries without popping them, and retired SHALL NOT count them.
REQ-018 Accept and pop are ignored in a cycle in which reset = 1.

Structure
REQ-019 Package wb_pkg SHALL hold the in_sel encodings (WB_SEL_ALU = 0, WB_SEL_MEM = 1, WB_SEL_LINK = 2, WB_SEL_RSVD = 3) and the entry record layout.
REQ-020 The 2-entry buffer SHALL be the sub-module wb_skid_fifo (parametrised by entry width), with source selection, r0 suppression, forwarding and the counter in writeback_pipe.

Verification
REQ-021 Scenario: reset, then accept {sel=01, mem=8'hA5, rd=3, we=1} with rf_ready = 1 -> next cycle rf_we = 1, rf_addr = 3, rf_data = A5; retired = 1 after pop.
REQ-022 Scenario: hold rf_ready = 0 and offer 3 entries -> in_ready = 0 after two accepts, third held; release rf_ready -> order preserved; retired = 3.
REQ-023 Scenario: accept {sel=00, alu=8'h7F, rd=0, we=1} -> rf_valid = 1, rf_we = 0, fwd_valid = 0; retired increments.
REQ-024 Scenario: accept sel=11 -> err_sel = 1 and stays 1 across further traffic; entry pops with rf_we = 0.
REQ-025 Scenario: buffer holds rd=2 (0x11) then rd=2 (0x22) -> fwd_data = 22; after one pop fwd_data = 22; after both pops fwd_valid = 0.
REQ-026 Scenario: CNT_W = 4, 17 pops -> retired = 1; assert reset with 2 entries -> rf_valid = 0 and retired = 0 next cycle.
